// File: rtl/level_debounce.sv
// Level debouncer: synchronises a raw level and only passes changes that hold for MIN_HIGH/MIN_LOW cycles.
// Latency: a sustained change on d shows on q after SYNC_STAGES + N clock edges, where N is the width for the new level.
// Backpressure: none. This is a free-running stream stage, so rejected candidates are only reported via glitch/glitch_cnt.
//
// Ports:
//   clock, rst_n      - rising-edge clock, asynchronous active-low reset
//   d                 - raw level, may be asynchronous to clock
//   glitch_clr        - synchronous clear of glitch_cnt (wins over a same-cycle increment)
//   q                 - debounced level
//   q_raising/falling - one-cycle strobes coinciding with the first cycle of the new q
//   glitch            - one-cycle strobe when a candidate change is rejected
//   glitch_cnt        - saturating count of rejected candidates
//   busy              - registered, high while a candidate is being qualified
module level_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 100,
    parameter int MIN_LOW     = 100
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        d,
    input  logic        glitch_clr,
    output logic        q,
    output logic        q_raising,
    output logic        q_falling,
    output logic        glitch,
    output logic [15:0] glitch_cnt,
    output logic        busy
);

    localparam int MAX_N  = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int CW_RAW = $clog2(MAX_N + 1);
    // The counter only ever reaches N-1 (<= 4095), so 12 bits is enough even for N = 4096.
    localparam int CW     = (CW_RAW > 12) ? 12 : ((CW_RAW < 1) ? 1 : CW_RAW);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic [CW-1:0]          cnt;
    logic                   sd;
    logic [CW-1:0]          target;

    assign sd = sync_chain[SYNC_STAGES-1];

    // Terminal count for the candidate level: qualification completes when cnt reaches N-1.
    assign target = sd ? CW'(MIN_HIGH - 1) : CW'(MIN_LOW - 1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE;
            cnt        <= '0;
            q          <= 1'b0;
            q_raising  <= 1'b0;
            q_falling  <= 1'b0;
            glitch     <= 1'b0;
            glitch_cnt <= '0;
            busy       <= 1'b0;
        end else begin
            q_raising <= 1'b0;
            q_falling <= 1'b0;
            glitch    <= 1'b0;

            case (state)
                STABLE: begin
                    if (sd != q) begin
                        if (target == '0) begin
                            // Width of one cycle: accept immediately without visiting QUALIFY.
                            q         <= sd;
                            q_raising <= sd;
                            q_falling <= ~sd;
                            cnt       <= '0;
                        end else begin
                            cnt   <= CW'(1);
                            state <= QUALIFY;
                            busy  <= 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                QUALIFY: begin
                    if (sd != q) begin
                        if (cnt == target) begin
                            q         <= sd;
                            q_raising <= sd;
                            q_falling <= ~sd;
                            cnt       <= '0;
                            state     <= STABLE;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        // Level returned before the minimum width: reject, restart from scratch next time.
                        glitch <= 1'b1;
                        cnt    <= '0;
                        state  <= STABLE;
                        busy   <= 1'b0;
                        if (glitch_cnt != 16'hFFFF) begin
                            glitch_cnt <= glitch_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase

            // Clear overrides any increment issued above in the same cycle.
            if (glitch_clr) begin
                glitch_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/level_debounce.md
Name: level_debounce

Overview:
- Upstream conditioning stage for the fixed-latency level delay line.
- Synchronises a raw asynchronous level and rejects pulses shorter than a programmable minimum high or low width.
- Output edges are therefore spaced at least MIN_HIGH or MIN_LOW cycles apart, so a downstream delay with latency not greater than those minimums never holds more than one edge of each polarity in flight.
- Also produces output edge strobes and a saturating glitch counter for status.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on d; legal range 1..4.
- MIN_HIGH, 100: consecutive synchronised-high cycles required before q rises; legal range 1..4096.
- MIN_LOW, 100: consecutive synchronised-low cycles required before q falls; legal range 1..4096.
- Counter width is derived internally: smallest width holding max(MIN_HIGH, MIN_LOW), maximum 12 bits.

Ports:
- clock, input, 1: single clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- d, input, 1: raw level, may be asynchronous to clock.
- glitch_clr, input, 1: synchronous clear of glitch_cnt.
- q, output, 1: debounced level.
- q_raising, output, 1: one-cycle strobe, high in the cycle q becomes 1.
- q_falling, output, 1: one-cycle strobe, high in the cycle q becomes 0.
- glitch, output, 1: one-cycle strobe when a candidate change is rejected.
- glitch_cnt, output, 16: saturating count of rejected changes.
- busy, output, 1: high while in QUALIFY.

Behaviour:
- Reset (async assert, clocked release): sync chain, q, q_raising, q_falling, glitch, glitch_cnt, busy and the counter all go to 0. State = STABLE.
- Synchroniser: d shifts through SYNC_STAGES flops. sd = last stage.
- FSM states: STABLE, QUALIFY. N = MIN_HIGH when sd=1, MIN_LOW when sd=0.
- STABLE, sd == q: hold, cnt = 0.
- STABLE, sd != q, N == 1: q <= sd and strobe at this edge; stay in STABLE.
- STABLE, sd != q, N > 1: cnt <= 1, go to QUALIFY.
- QUALIFY, sd != q, cnt == N-1: q <= sd, assert the matching strobe, cnt <= 0, go to STABLE.
- QUALIFY, sd != q, cnt < N-1: cnt <= cnt + 1.
- QUALIFY, sd == q: glitch <= 1 for one cycle, cnt <= 0, go to STABLE. q is unchanged and no edge strobe is issued.
- Latency: number the edge that first samples a new d as edge 1. A sustained change appears on q after edge SYNC_STAGES + N.
- Strobes are registered and coincide with the first cycle of the new q value.
- The qualification counter restarts on every new candidate; there is no accumulation across glitches.
- glitch_cnt increments on each glitch and saturates at 0xFFFF.
- glitch_clr has priority: if glitch_clr and a glitch occur in the same cycle, glitch_cnt <= 0. The glitch strobe still pulses.
- busy = (state == QUALIFY), registered.
- If d is high at reset release, q rises after SYNC_STAGES + MIN_HIGH edges. This is normal qualification; there is no special case.
- Reset asserted mid-qualification aborts immediately: q = 0, cnt = 0, no strobes.
- Strobes are mutually exclusive by construction: q_raising, q_falling and glitch never assert in the same cycle.

Test Plan:
All scenarios use SYNC_STAGES=2, MIN_HIGH=8, MIN_LOW=4.
- Release reset with d=0 held for 100 cycles -> q=0, all strobes 0, glitch_cnt=0, busy=0 throughout.
- d set high before edge 10 and held -> busy high after edge 12; q and q_raising become 1 after edge 19; q_raising drops after edge 20; glitch never asserts.
- d high for edges 10..14 only (5 cycles) -> q stays 0; glitch pulses after edge 17; glitch_cnt=1; busy low after edge 17.
- From stable q=1, d low for exactly 4 sampled cycles then high -> q and q_falling become 0 after edge e+5. Repeat with 3 low cycles -> q stays 1, one glitch pulse, glitch_cnt increments by 1.
- Drive 65540 rejected pulses -> glitch_cnt holds 0xFFFF. Assert glitch_clr for one cycle together with a glitch -> glitch_cnt=0 and the glitch strobe still seen. The next glitch gives glitch_cnt=1.
- Assert rst_n low mid-edge at cycle 5 of an 8-cycle qualification with q=0 -> q, busy and all strobes 0 immediately without a clock. After release with d high, q rises after edge 10 counted from release.
